// File: rtl/wiegand26_tx.sv
// ---------------------------------------------------------------------------
// wiegand26_tx
//
// Wiegand-26 transmitter. Serialises one 26-bit frame, MSB first, onto the
// two-wire D0/D1 interface. Each bit is a low pulse of PULSE_CYC cycles on the
// line that encodes it (wd1 for a 1, wd0 for a 0), followed by GAP_CYC cycles
// with both lines high.
//
// Optional feature macro: WIEGAND26_PARITY_GEN_EN
//   defined   : the frame is {EP, data[24:1], OP}, with parity computed at
//               acceptance; data[25] and data[0] are ignored.
//   undefined : data[25:0] is sent verbatim, so the host supplies parity.
//
// Parameters
//   PULSE_CYC : low-pulse width per bit in CLK cycles (1..65535)
//   GAP_CYC   : high time after each pulse in CLK cycles (1..65535)
//
// Ports
//   CLK       : clock, rising edge
//   nHRESET   : asynchronous active-low reset
//   en        : transmitter enable; low aborts a frame and blocks new ones
//   start     : level-sampled request, accepted only in IDLE with en=1
//   data[25:0]: frame payload, data[25] sent first
//   wd0       : Wiegand D0 line, idle high, pulses low for a 0 bit
//   wd1       : Wiegand D1 line, idle high, pulses low for a 1 bit
//   busy      : high from start acceptance until frame end or abort
//   done      : one-cycle pulse when a frame completes normally
// ---------------------------------------------------------------------------
module wiegand26_tx #(
  parameter int unsigned PULSE_CYC = 100,
  parameter int unsigned GAP_CYC   = 1900
) (
  input  logic        CLK,
  input  logic        nHRESET,
  input  logic        en,
  input  logic        start,
  input  logic [25:0] data,
  output logic        wd0,
  output logic        wd1,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // The interval counter counts down to zero, so an interval of N cycles
  // reloads with N-1.
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 32'd1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 32'd1);

  // Even parity: XOR of the covered bits.
  function automatic logic even_par12(input logic [11:0] v);
    return ^v;
  endfunction

  // Odd parity: inverted XOR of the covered bits.
  function automatic logic odd_par12(input logic [11:0] v);
    return ~(^v);
  endfunction

  state_t      state_r;
  logic [25:0] shift_r;
  logic [4:0]  bit_cnt_r;
  logic [15:0] cnt_r;
  logic [25:0] frame_s;

  // Frame image latched into the shift register on acceptance.
  always_comb begin
    frame_s = 26'd0;
`ifdef WIEGAND26_PARITY_GEN_EN
    frame_s = {even_par12(data[24:13]), data[24:1], odd_par12(data[12:1])};
`else
    frame_s = data;
`endif
  end

  // Transmit FSM with registered line, busy and done outputs.
  always_ff @(posedge CLK or negedge nHRESET) begin
    if (!nHRESET) begin
      state_r   <= ST_IDLE;
      shift_r   <= 26'd0;
      bit_cnt_r <= 5'd0;
      cnt_r     <= 16'd0;
      wd0       <= 1'b1;
      wd1       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (!en) begin
      // Abort: release both lines and drop busy without signalling done.
      state_r <= ST_IDLE;
      wd0     <= 1'b1;
      wd1     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_r   <= frame_s;
            bit_cnt_r <= 5'd25;
            cnt_r     <= PULSE_LD;
            state_r   <= ST_PULSE;
            busy      <= 1'b1;
            // Exactly one line goes low, chosen by the first bit.
            wd0       <= frame_s[25];
            wd1       <= ~frame_s[25];
          end else begin
            busy <= 1'b0;
            wd0  <= 1'b1;
            wd1  <= 1'b1;
          end
        end

        ST_PULSE: begin
          if (cnt_r == 16'd0) begin
            state_r <= ST_GAP;
            cnt_r   <= GAP_LD;
            wd0     <= 1'b1;
            wd1     <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end

        ST_GAP: begin
          if (cnt_r == 16'd0) begin
            if (bit_cnt_r == 5'd0) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              // shift_r[24] becomes the new MSB after this shift.
              shift_r   <= {shift_r[24:0], 1'b0};
              bit_cnt_r <= bit_cnt_r - 5'd1;
              cnt_r     <= PULSE_LD;
              state_r   <= ST_PULSE;
              wd0       <= shift_r[24];
              wd1       <= ~shift_r[24];
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end

        ST_FIN: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          wd0     <= 1'b1;
          wd1     <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wiegand26_tx.sv
// ---------------------------------------------------------------------------
// tb_wiegand26_tx
//
// Directed bench for wiegand26_tx. Two instances share clock and reset:
// u_dut_a uses P=4, G=12 and u_dut_b uses P=1, G=1. Expected frames are
// hand-computed constants for both settings of WIEGAND26_PARITY_GEN_EN.
// ---------------------------------------------------------------------------
module tb_wiegand26_tx;

  localparam int PA = 4;
  localparam int GA = 12;
  localparam int PB = 1;
  localparam int GB = 1;

  localparam logic [25:0] D_ABC  = 26'h3579BDE;
  localparam logic [25:0] D_ZERO = 26'h0000000;
  localparam logic [25:0] D_FFF  = 26'h3FFE000;
`ifdef WIEGAND26_PARITY_GEN_EN
  localparam logic [25:0] F_ABC  = 26'h3579BDF;
  localparam logic [25:0] F_ZERO = 26'h0000001;
  localparam logic [25:0] F_FFF  = 26'h1FFE001;
`else
  localparam logic [25:0] F_ABC  = 26'h3579BDE;
  localparam logic [25:0] F_ZERO = 26'h0000000;
  localparam logic [25:0] F_FFF  = 26'h3FFE000;
`endif

  logic        CLK = 1'b0;
  logic        nHRESET;
  logic        en_a, start_a, en_b, start_b;
  logic [25:0] data_a, data_b;
  logic        wd0_a, wd1_a, busy_a, done_a;
  logic        wd0_b, wd1_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wiegand26_tx #(.PULSE_CYC(PA), .GAP_CYC(GA)) u_dut_a (
    .CLK(CLK), .nHRESET(nHRESET), .en(en_a), .start(start_a), .data(data_a),
    .wd0(wd0_a), .wd1(wd1_a), .busy(busy_a), .done(done_a)
  );

  wiegand26_tx #(.PULSE_CYC(PB), .GAP_CYC(GB)) u_dut_b (
    .CLK(CLK), .nHRESET(nHRESET), .en(en_b), .start(start_b), .data(data_b),
    .wd0(wd0_b), .wd1(wd1_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output bundle {wd0, wd1, busy, done}; idle is 4'b1100.
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {wd0_b, wd1_b, busy_b, done_b} : {wd0_a, wd1_a, busy_a, done_a};
  endfunction

  // Expected bundle for cycle j after the accepting edge.
  function automatic logic [3:0] exp_outs(input logic [25:0] frame, input int p, input int g, input int j);
    int   t;
    int   i;
    logic low;
    logic b;
    t = p + g;
    if (j < 26 * t) begin
      i   = j / t;
      low = ((j % t) < p);
      b   = frame[25 - i];
      return {~(low & ~b), ~(low & b), 1'b1, 1'b0};
    end else if (j == 26 * t) begin
      return 4'b1101;
    end else begin
      return 4'b1100;
    end
  endfunction

  // Called just after the accepting edge; checks every cycle through FIN and
  // the following IDLE cycle, ending at the negedge inside that IDLE cycle.
  task automatic check_frame(input bit sel, input logic [25:0] frame, input int p, input int g, input string name);
    int t;
    t = p + g;
    for (int j = 0; j <= 26 * t + 1; j++) begin
      @(negedge CLK);
      check_val($sformatf("%s_c%0d", name, j), {28'd0, outs(sel)}, {28'd0, exp_outs(frame, p, g, j)});
    end
  endtask

  task automatic send_a(input logic [25:0] d);
    @(posedge CLK);
    #1;
    data_a  = d;
    start_a = 1'b1;
    @(posedge CLK);
    #1;
    start_a = 1'b0;
  endtask

  initial begin
    nHRESET = 1'b0;
    en_a = 1'b1; start_a = 1'b0; data_a = 26'd0;
    en_b = 1'b1; start_b = 1'b0; data_b = 26'd0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check_val("rst_a", {28'd0, outs(1'b0)}, 32'hC);
    check_val("rst_b", {28'd0, outs(1'b1)}, 32'hC);
    nHRESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_val("idle_a", {28'd0, outs(1'b0)}, 32'hC);

    // Main frame, P=4 G=12: 416 cycles to done.
    send_a(D_ABC);
    check_frame(1'b0, F_ABC, PA, GA, "abc");

    // All-zero payload.
    send_a(D_ZERO);
    check_frame(1'b0, F_ZERO, PA, GA, "zero");

    // en low blocks new frames even with start high.
    en_a = 1'b0;
    start_a = 1'b1;
    data_a = D_ABC;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      check_val($sformatf("blocked_c%0d", j), {28'd0, outs(1'b0)}, 32'hC);
    end
    start_a = 1'b0;
    en_a = 1'b1;

    // Abort during the 10th pulse (bit index 9), cycle 2 of that pulse.
    send_a(D_ABC);
    for (int j = 0; j <= 9 * (PA + GA) + 2; j++) @(negedge CLK);
    check_val("pulse10", {28'd0, outs(1'b0)}, {28'd0, exp_outs(F_ABC, PA, GA, 9 * (PA + GA) + 2)});
    en_a = 1'b0;
    start_a = 1'b1;
    @(negedge CLK);
    check_val("abort", {28'd0, outs(1'b0)}, 32'hC);
    // Start re-issued right at the next edge sends the full frame.
    en_a = 1'b1;
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    check_frame(1'b0, F_ABC, PA, GA, "restart");

    // Back-to-back with start held high, P=1 G=1 (52-cycle frames).
    @(posedge CLK);
    #1;
    data_b = D_FFF;
    start_b = 1'b1;
    @(posedge CLK);
    check_frame(1'b1, F_FFF, PB, GB, "b2b1");
    @(posedge CLK);
    check_frame(1'b1, F_FFF, PB, GB, "b2b2");
    start_b = 1'b0;
    @(negedge CLK);
    check_val("b2b_idle", {28'd0, outs(1'b1)}, 32'hC);

    // Asynchronous reset mid-pulse releases lines without a clock edge.
    send_a(D_ABC);
    repeat (2) @(negedge CLK);
    check_val("prerst", {28'd0, outs(1'b0)}, {28'd0, exp_outs(F_ABC, PA, GA, 1)});
    #2;
    nHRESET = 1'b0;
    #1;
    check_val("rst_async", {28'd0, outs(1'b0)}, 32'hC);
    @(negedge CLK);
    nHRESET = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      check_val($sformatf("post_rst_c%0d", j), {28'd0, outs(1'b0)}, 32'hC);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wiegand26_tx.md
# wiegand26_tx

Wiegand-26 transmitter that serialises one 26-bit frame onto a two-wire D0/D1 interface for an external access controller. It is the outbound counterpart of the board's Wiegand receivers. It sits behind the CPLD host-bus register file: the host loads the payload, pulses `start`, and waits for `done` or polls `busy`. Pulse and gap widths are counted in CLK cycles; CLK is nominally 1 MHz, so one cycle is 1 µs.

## Interface
- `PULSE_CYC`, default 100: low-pulse width per bit in CLK cycles, 1..65535.
- `GAP_CYC`, default 1900: high time after each pulse in CLK cycles, 1..65535.
- `CLK` in 1: clock, rising-edge.
- `nHRESET` in 1: reset nHRESET, asynchronous, active-low; clock CLK.
- `en` in 1: transmitter enable. Low aborts any frame in progress and blocks new frames.
- `start` in 1: level-sampled request, accepted only in IDLE with `en`=1.
- `data` in 26: frame, `data[25]` sent first. See Configuration for parity handling.
- `wd0` out 1: Wiegand D0 line, idle high, pulses low for a 0 bit.
- `wd1` out 1: Wiegand D1 line, idle high, pulses low for a 1 bit.
- `busy` out 1: high from start acceptance until frame end or abort.
- `done` out 1: one-cycle pulse when a frame completes normally.

## Operation
- States are IDLE, PULSE, GAP, FIN.
- IDLE:
  - `wd0`=`wd1`=1, `busy`=0.
  - On `start`&`en`, latch the frame into a shift register, set the bit counter to 25, and go to PULSE.
  - `data` is not sampled again after acceptance.
- PULSE:
  - Drive the line selected by the current frame MSB low (`wd1` for 1, `wd0` for 0); the other line stays high.
  - After `PULSE_CYC` cycles, go to GAP.
- GAP:
  - Both lines high.
  - After `GAP_CYC` cycles: if the bit counter is 0, go to FIN; otherwise shift left, decrement the counter, and go to PULSE.
- FIN: `done`=1 for one cycle, `busy`=0, go to IDLE.
- Abort: `en`=0 in any state forces IDLE on the next edge. Lines go high, `busy` goes 0, and no `done` is issued.
- `start` while `busy`=1 is ignored. There is no queueing.
- The interval counter is 16 bits unsigned, reloaded at each state entry.
- Both lines are never low simultaneously.
- Async reset: `wd0`=1, `wd1`=1, `busy`=0, `done`=0, state IDLE, shift register 0, counters 0. Reset mid-frame releases both lines immediately, without waiting for a clock.

## Timing
- All outputs are registered.
- `start` sampled high at edge k:
  - `busy`=1 and the first pulse begin after edge k.
  - Bit i (i=0 is the first bit sent) is low from edge k+i·(P+G) to edge k+i·(P+G)+P, where P=`PULSE_CYC` and G=`GAP_CYC`.
  - `done`=1 during the cycle after edge k+26·(P+G); `busy` falls at that same edge.
- Frame length is exactly 26·(P+G) cycles; with defaults this is 52 ms.
- The earliest next acceptance is the edge after `done`.
- Aborting at edge m releases the lines after edge m. A start sampled at edge m+1 with `en`=1 is accepted.

## Configuration
- `WIEGAND26_PARITY_GEN_EN` defined:
  - The frame is built as {EP, `data[24:1]`, OP}. `data[25]` and `data[0]` are ignored.
  - EP is the even parity of `data[24:13]` (XOR of those bits).
  - OP is the odd parity of `data[12:1]` (inverted XOR of those bits).
  - Parity is computed at acceptance.
- Not defined: `data[25:0]` is sent verbatim. The host supplies parity.

## Test plan
- P=4, G=12, macro defined, `data[24:1]`=24'hABCDEF, `start` pulsed → wire sequence equals frame 26'h3579BDF, MSB first. The first pulse is on `wd1`. Each pulse is 4 cycles, each gap 12 cycles. `done` arrives 416 cycles after acceptance.
- Macro undefined, `data`=26'h0000000 → 26 pulses, all on `wd0`, with `wd1` constantly high. `done` arrives after 26·(P+G) cycles.
- `start` held high continuously → frames are back-to-back, separated by exactly one IDLE cycle. No start is accepted while `busy`=1.
- `en` dropped during the 10th pulse → both lines high and `busy`=0 on the next edge, and no `done`. A start re-issued with `en`=1 sends the full frame from bit 25.
- `nHRESET` asserted mid-pulse → `wd0`/`wd1` go high asynchronously and `busy`=0. After release, the block is idle until the next `start`.
- P=1, G=1 → each bit is 1 low cycle followed by 1 high cycle, the frame is 52 cycles, and the lines are never low together.
